// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared constants, size encodings and FSM states for mem_port_initiator.
package mem_port_pkg;
  localparam int BYTE = 8;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;
  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
`ifdef MEM_PORT_READBACK_EN
    VERIFY,
`endif
    RESP
  } state_e;
  function automatic logic [3:0] size_bytes(input logic [1:0] s);
    return s == SIZE_DOUBLE ? 4'd8 : s == SIZE_WORD ? 4'd4 : s == SIZE_HALF ? 4'd2 : 4'd1;
  endfunction
endpackage

// File: rtl/mem_port_if.sv
// mem_port_if: core request/response handshake plus RAM port signals of mem_port_initiator.
interface mem_port_if #(
  parameter int ADDRESS_SIZE = 11,
  parameter int MEM_WORD_SIZE = 64
);
  logic reqValid;
  logic reqReady;
  logic reqWrite;
  logic [1:0] reqSize;
  logic reqSigned;
  logic [ADDRESS_SIZE-1:0] reqAddress;
  logic [MEM_WORD_SIZE-1:0] reqData;
  logic respValid;
  logic respReady;
  logic [MEM_WORD_SIZE-1:0] respData;
  logic respError;
  logic [ADDRESS_SIZE-1:0] ramAddress;
  logic ramIsReading;
  logic [MEM_WORD_SIZE-1:0] ramDataIn;
  logic [MEM_WORD_SIZE-1:0] ramDataOut;
  modport master (
    input reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqData, respReady, ramDataOut,
    output reqReady, respValid, respData, respError, ramAddress, ramIsReading, ramDataIn
  );
  modport slave (
    output reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqData, respReady, ramDataOut,
    input reqReady, respValid, respData, respError, ramAddress, ramIsReading, ramDataIn
  );
endinterface

// File: rtl/mem_lane_merge.sv
// mem_lane_merge: big-endian byte-lane extract/sign-extend and store merge over one RAM window.
module mem_lane_merge #(
  parameter int W = 64,
  parameter int B = 8
) (
  input  logic [W-1:0] win,
  input  logic [2:0]   off,
  input  logic [3:0]   n,
  input  logic [W-1:0] wdata,
  input  logic         sgn,
  output logic [W-1:0] merged,
  output logic [W-1:0] load
);
  localparam int S = $clog2(W) + 1;
  logic [S-1:0] sh_hi, sh_off;
  logic [W-1:0] mask, top_al, wal;
  logic signed [W-1:0] ext;
  assign sh_hi = S'(W - B * int'(n));
  assign sh_off = S'(B * int'(off));
  // Accessed bytes shifted to the top, then down again: arithmetic shift gives sign extension.
  assign top_al = win << sh_off;
  assign ext = $signed(top_al) >>> sh_hi;
  assign load = sgn ? ext : top_al >> sh_hi;
  assign mask = ({W{1'b1}} << sh_hi) >> sh_off;
  assign wal = (wdata << sh_hi) >> sh_off;
  assign merged = (win & ~mask) | (wal & mask);
endmodule

// File: rtl/mem_port_initiator.sv
// mem_port_initiator: sized load/store initiator for a big-endian 64-bit RAM port (read, then read-modify-write).
// Defining MEM_PORT_READBACK_EN adds a VERIFY read after each store write.
module mem_port_initiator import mem_port_pkg::*; #(
  parameter int ADDRESS_SIZE = 11,
  parameter int MEM_WORD_SIZE = 64,
  parameter int BYTE = 8
) (
  input logic clk,
  input logic reset,
  mem_port_if.master bus
);
  localparam logic [ADDRESS_SIZE:0] DEPTH = {1'b1, {ADDRESS_SIZE{1'b0}}};
  localparam logic [ADDRESS_SIZE-1:0] TOP_BASE = ~ADDRESS_SIZE'(MEM_WORD_SIZE / BYTE - 1);
  state_e state_q, state_d;
  logic write_q, write_d, signed_q, signed_d, err_q, err_d, rd_q, rd_d, oob;
  logic [3:0] n_q, n_d, req_n;
  logic [2:0] off_q, off_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d, base;
  logic [MEM_WORD_SIZE-1:0] data_q, data_d, rdata_q, rdata_d, din_q, din_d, merged, load_val;
  assign req_n = size_bytes(bus.reqSize);
  assign oob = {1'b0, bus.reqAddress} + (ADDRESS_SIZE + 1)'(req_n) > DEPTH;
  assign base = bus.reqAddress > TOP_BASE ? TOP_BASE : bus.reqAddress;
  mem_lane_merge #(.W(MEM_WORD_SIZE), .B(BYTE)) u_merge (
    .win(bus.ramDataOut),
    .off(off_q),
    .n(n_q),
    .wdata(data_q),
    .sgn(signed_q),
    .merged(merged),
    .load(load_val)
  );
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    signed_d = signed_q;
    n_d = n_q;
    off_d = off_q;
    data_d = data_q;
    addr_d = addr_q;
    rdata_d = rdata_q;
    err_d = err_q;
    din_d = din_q;
    rd_d = 1'b1;
    case (state_q)
      IDLE: if (bus.reqValid) begin
        write_d = bus.reqWrite;
        signed_d = bus.reqSigned;
        n_d = req_n;
        off_d = 3'(bus.reqAddress - base);
        data_d = bus.reqData;
        addr_d = base;
        rdata_d = '0;
        err_d = oob;
        state_d = oob ? RESP : READ;
      end
      READ: begin
        din_d = write_q ? merged : din_q;
        rdata_d = write_q ? '0 : load_val;
        rd_d = !write_q;
        state_d = write_q ? WRITE : RESP;
      end
`ifdef MEM_PORT_READBACK_EN
      WRITE: state_d = VERIFY;
      VERIFY: begin
        err_d = bus.ramDataOut != din_q;
        state_d = RESP;
      end
`else
      WRITE: state_d = RESP;
`endif
      RESP: state_d = bus.respReady ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      signed_q <= 1'b0;
      n_q <= '0;
      off_q <= '0;
      data_q <= '0;
      addr_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      din_q <= '0;
      rd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      signed_q <= signed_d;
      n_q <= n_d;
      off_q <= off_d;
      data_q <= data_d;
      addr_q <= addr_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      din_q <= din_d;
      rd_q <= rd_d;
    end
  end
  assign bus.reqReady = state_q == IDLE;
  assign bus.respValid = state_q == RESP;
  assign bus.respData = rdata_q;
  assign bus.respError = err_q;
  assign bus.ramAddress = addr_q;
  assign bus.ramIsReading = rd_q;
  assign bus.ramDataIn = din_q;
endmodule

// File: tb/tb_mem_port_initiator.sv
// tb_mem_port_initiator: directed load/store/error/backpressure/reset vectors against a byte-array RAM model.
module tb_mem_port_initiator;
  import mem_port_pkg::*;
  localparam int ST_LAT = `ifdef MEM_PORT_READBACK_EN 4 `else 3 `endif ;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] mem [2048];
  int wr_cnt = 0;
  int n_chk = 0;
  int n_pass = 0;
  mem_port_if bus();
  mem_port_initiator dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    bus.ramDataOut = '0;
    for (int i = 0; i < 8; i++) bus.ramDataOut[63-8*i -: 8] = mem[11'(int'(bus.ramAddress) + i)];
  end
  always @(posedge clk) if (!bus.ramIsReading) begin
    for (int i = 0; i < 8; i++) mem[11'(int'(bus.ramAddress) + i)] <= bus.ramDataIn[63-8*i -: 8];
    wr_cnt <= wr_cnt + 1;
  end
  function automatic logic [63:0] peek(input int a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = mem[11'(a + i)];
    return r;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic reset_chk(input string tag);
    check({tag, "/reqReady"}, 64'(bus.reqReady), 64'd1);
    check({tag, "/respValid"}, 64'(bus.respValid), 64'd0);
    check({tag, "/respData"}, bus.respData, 64'd0);
    check({tag, "/respError"}, 64'(bus.respError), 64'd0);
    check({tag, "/ramIsReading"}, 64'(bus.ramIsReading), 64'd1);
    check({tag, "/ramAddress"}, 64'(bus.ramAddress), 64'd0);
    check({tag, "/ramDataIn"}, bus.ramDataIn, 64'd0);
  endtask
  task automatic send(input logic w, input logic [1:0] sz, input logic sg, input logic [10:0] a, input logic [63:0] d);
    bus.reqValid = 1'b1;
    bus.reqWrite = w;
    bus.reqSize = sz;
    bus.reqSigned = sg;
    bus.reqAddress = a;
    bus.reqData = d;
    @(posedge clk);
    @(negedge clk);
    bus.reqValid = 1'b0;
  endtask
  task automatic wait_resp(output int lat, output int lows);
    lat = 1;
    lows = 0;
    while (!bus.respValid && lat < 10) begin
      lows += int'(!bus.ramIsReading);
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic ack();
    bus.respReady = 1'b1;
    @(posedge clk);
    #1 bus.respReady = 1'b0;
    @(negedge clk);
  endtask
  task automatic load_chk(input string tag, input logic [1:0] sz, input logic sg, input logic [10:0] a, input logic [63:0] exp);
    int lat, lows;
    send(1'b0, sz, sg, a, 64'hDEAD_BEEF_DEAD_BEEF);
    wait_resp(lat, lows);
    check({tag, "/data"}, bus.respData, exp);
    check({tag, "/lat"}, 64'(lat), 64'd2);
    check({tag, "/err"}, 64'(bus.respError), 64'd0);
    check({tag, "/wr_low"}, 64'(lows), 64'd0);
    ack();
  endtask
  initial begin
    int lat, lows, w0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mem[16'h010 + i] = 8'(i + 1);
      mem[16'h7F8 + i] = 8'(8'hA0 + i);
      mem[16'h020 + i] = 8'h55;
    end
    bus.reqValid = 1'b0;
    bus.reqWrite = 1'b0;
    bus.reqSize = SIZE_BYTE;
    bus.reqSigned = 1'b0;
    bus.reqAddress = '0;
    bus.reqData = '0;
    bus.respReady = 1'b0;
    repeat (3) @(negedge clk);
    reset_chk("reset");
    reset = 1'b0;
    @(negedge clk);
    load_chk("dload", SIZE_DOUBLE, 1'b0, 11'h010, 64'h0102_0304_0506_0708);
    mem[11'h013] = 8'h80;
    load_chk("bload_s", SIZE_BYTE, 1'b1, 11'h013, 64'hFFFF_FFFF_FFFF_FF80);
    load_chk("bload_u", SIZE_BYTE, 1'b0, 11'h013, 64'h0000_0000_0000_0080);
    load_chk("hload_top", SIZE_HALF, 1'b0, 11'h7FE, 64'h0000_0000_0000_A6A7);
    w0 = wr_cnt;
    send(1'b1, SIZE_HALF, 1'b0, 11'h7FE, 64'h1122_3344_5566_BEEF);
    wait_resp(lat, lows);
    check("hstore/lat", 64'(lat), 64'(ST_LAT));
    check("hstore/wr_low", 64'(lows), 64'd1);
    check("hstore/wr_cnt", 64'(wr_cnt - w0), 64'd1);
    check("hstore/err", 64'(bus.respError), 64'd0);
    check("hstore/data", bus.respData, 64'd0);
    check("hstore/ramAddress", 64'(bus.ramAddress), 64'h7F8);
    check("hstore/ramDataIn", bus.ramDataIn, 64'hA0A1_A2A3_A4A5_BEEF);
    check("hstore/mem", peek(11'h7F8), 64'hA0A1_A2A3_A4A5_BEEF);
    ack();
    load_chk("wload_s", SIZE_WORD, 1'b1, 11'h7FC, 64'hFFFF_FFFF_A4A5_BEEF);
    load_chk("dload_edge", SIZE_DOUBLE, 1'b0, 11'h7F8, 64'hA0A1_A2A3_A4A5_BEEF);
    w0 = wr_cnt;
    send(1'b0, SIZE_WORD, 1'b0, 11'h7FE, 64'd0);
    wait_resp(lat, lows);
    check("oob_ld/lat", 64'(lat), 64'd1);
    check("oob_ld/err", 64'(bus.respError), 64'd1);
    check("oob_ld/data", bus.respData, 64'd0);
    ack();
    send(1'b1, SIZE_WORD, 1'b0, 11'h7FE, 64'h0000_0000_DEAD_BEEF);
    wait_resp(lat, lows);
    check("oob_st/lat", 64'(lat), 64'd1);
    check("oob_st/err", 64'(bus.respError), 64'd1);
    check("oob_st/wr_low", 64'(lows), 64'd0);
    check("oob_st/wr_cnt", 64'(wr_cnt - w0), 64'd0);
    check("oob_st/mem", peek(11'h7F8), 64'hA0A1_A2A3_A4A5_BEEF);
    ack();
    send(1'b0, SIZE_BYTE, 1'b0, 11'h010, 64'd0);
    wait_resp(lat, lows);
    check("bp/lat", 64'(lat), 64'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp/respValid", 64'(bus.respValid), 64'd1);
      check("bp/respData", bus.respData, 64'h01);
      check("bp/reqReady", 64'(bus.reqReady), 64'd0);
    end
    bus.respReady = 1'b1;
    bus.reqValid = 1'b1;
    bus.reqWrite = 1'b0;
    bus.reqSize = SIZE_WORD;
    bus.reqSigned = 1'b0;
    bus.reqAddress = 11'h014;
    @(posedge clk);
    #1 bus.respReady = 1'b0;
    @(negedge clk);
    check("bp2/reqReady_idle", 64'(bus.reqReady), 64'd1);
    check("bp2/respValid_idle", 64'(bus.respValid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.reqValid = 1'b0;
    check("bp2/reqReady_busy", 64'(bus.reqReady), 64'd0);
    check("bp2/ramAddress", 64'(bus.ramAddress), 64'h014);
    wait_resp(lat, lows);
    check("bp2/lat", 64'(lat), 64'd2);
    check("bp2/data", bus.respData, 64'h0000_0000_0506_0708);
    ack();
    w0 = wr_cnt;
    send(1'b1, SIZE_DOUBLE, 1'b0, 11'h020, 64'h1122_3344_5566_7788);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_chk("rst_mid");
    check("rst_mid/wr_cnt", 64'(wr_cnt - w0), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid/no_resp", 64'(bus.respValid), 64'd0);
    check("rst_mid/mem", peek(11'h020), 64'h5555_5555_5555_5555);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_initiator.md
# mem_port_initiator

Initiator for the byte-addressed, big-endian 64-bit RAM port (`address`, `isReading`, `dataIn`, `dataOut`).

- Accepts sized load/store requests (byte, half, word, double; any alignment) from the core over a valid/ready handshake.
- Issues the RAM-side accesses: a single read for loads, and read-modify-write for stores.
- Returns right-aligned, optionally sign-extended load data.
- Sits between the load/store stage and the RAM instance.

## Interface
Parameters:
- ADDRESS_SIZE, 11, RAM byte-address width; MEM_DEPTH = 2**ADDRESS_SIZE bytes
- MEM_WORD_SIZE, 64, RAM data width
- BYTE, 8, bits per byte lane

Ports:
- Clocking and reset: one clock `clk`; reset `reset` is synchronous, active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- reqValid  in  1  request present
- reqReady  out  1  high only in IDLE
- reqWrite  in  1  1 = store, 0 = load
- reqSize  in  2  0 byte, 1 half, 2 word, 3 double (n = 1, 2, 4, 8 bytes)
- reqSigned  in  1  sign-extend load result
- reqAddress  in  ADDRESS_SIZE  byte address of the most-significant byte
- reqData  in  MEM_WORD_SIZE  store data; low n bytes used
- respValid  out  1  response present
- respReady  in  1  response consumed
- respData  out  MEM_WORD_SIZE  load result, right-aligned; 0 for stores and errors
- respError  out  1  out-of-range access (or readback mismatch, see Configuration)
- ramAddress  out  ADDRESS_SIZE  drives RAM `address`
- ramIsReading  out  1  drives RAM `isReading`
- ramDataIn  out  MEM_WORD_SIZE  drives RAM `dataIn`
- ramDataOut  in  MEM_WORD_SIZE  from RAM `dataOut`

## Operation
- **FSM states:** IDLE, READ, WRITE, (VERIFY), RESP.
- **IDLE:**
  - On reqValid && reqReady, latch the request.
  - Error if reqAddress + n > MEM_DEPTH → go straight to RESP with respError=1; no RAM write occurs.
  - Otherwise → READ.
- **Window:**
  - base = min(reqAddress, MEM_DEPTH-8); offset = reqAddress - base (0..7).
  - Window byte i is ramDataOut[63-8i -: 8].
  - The accessed bytes are i = offset .. offset+n-1; big-endian, so byte i=offset is the most significant.
- **READ:**
  - ramAddress = base, ramIsReading = 1.
  - Capture ramDataOut at the end of the cycle.
  - Load → RESP. Store → WRITE.
- **Load result:**
  - Extract the n accessed bytes, right-align them.
  - Zero-extend, or sign-extend from the top extracted bit when reqSigned=1.
- **WRITE:**
  - ramIsReading = 0 for exactly one cycle.
  - ramDataIn = captured window with the accessed bytes replaced by reqData[8n-1:0] (MSB first); all other bytes unchanged.
  - Next state: RESP (or VERIFY).
- **RESP:**
  - respValid=1; respData and respError held stable until respReady.
  - On respReady → IDLE.
- **RAM write protection:**
  - ramIsReading=1 in every state except WRITE, because the RAM writes whenever `isReading` is low.
  - ramAddress and ramDataIn are registered and do not change during WRITE.
- **Reset values:**
  - State IDLE, reqReady=1, respValid=0, respData=0, respError=0.
  - ramIsReading=1, ramAddress=0, ramDataIn=0.
- **Reset mid-operation:**
  - Any pending request is discarded and no response is produced.
  - If reset is asserted during WRITE, that one write cycle completes (the RAM is combinational); ramIsReading returns to 1 at the next edge.

## Timing
- Request accepted at the edge closing cycle T.
- Cycle T+1: READ.
- Loads: respValid from T+2.
- Stores: WRITE in T+2, respValid from T+3 (T+4 with readback enabled).
- Errors: respValid from T+1.
- reqReady is low from T+1 until the cycle after the response handshake; no overlap between requests.
- Back-to-back: the next request can be accepted in the cycle following a respValid && respReady edge.
- All outputs are registered or decoded from state only; there are no combinational paths from the req*/resp* inputs.

## Configuration
- **MEM_PORT_READBACK_EN:**
  - Defined: stores add a VERIFY state after WRITE. It reads `base` back with ramIsReading=1 and compares against ramDataIn. A mismatch sets respError=1; the store still completes.
  - Undefined: the VERIFY state is absent; WRITE → RESP.

## Structure
- **Package `mem_port_pkg`:**
  - BYTE constant.
  - Size encodings SIZE_BYTE/HALF/WORD/DOUBLE.
  - State enum.
  - Function mapping size → byte count.
- **Sub-module `mem_lane_merge` (combinational):**
  - Inputs: window, offset, n, store data, signed flag.
  - Outputs: merged window and extracted/extended load value.
- **Top level:** FSM plus registers.

## Test plan
- **Double load:** RAM[0x010..0x017] = 01..08; double load at 0x010 → respData 0x0102030405060708, respValid at T+2, ramIsReading never low.
- **Byte load:** RAM[0x013] = 0x80; byte load at 0x013 → signed gives 0xFFFFFFFFFFFFFF80, unsigned gives 0x0000000000000080.
- **Half store near top:** half store 0xBEEF at 0x7FE → ramAddress 0x7F8; RAM[0x7FE]=0xBE, RAM[0x7FF]=0xEF; RAM[0x7F8..0x7FD] unchanged; ramIsReading low exactly one cycle.
- **Out-of-range load:** word load at 0x7FE → respError=1, respData=0 at T+1, no RAM write.
- **Response backpressure:** hold respReady low for 3 cycles → respValid/respData stable, reqReady low; then issue an immediate second request → it is accepted the cycle after the handshake.
- **Reset during store:** reset asserted during READ of a store to 0x020 → RAM[0x020..0x027] unchanged, all outputs at reset values, no response.
